// File: rtl/ifetch_line_buffer.sv
// ifetch_line_buffer: one-line instruction buffer between the PC and IF/ID.
// Hits are served combinationally from the buffered line. A miss stalls the PC
// and fetches the whole line from instruction memory over a req/ack handshake.
module ifetch_line_buffer #(
  parameter int LINE_WORDS = 8,
  parameter int OFF_BITS   = 5,
  parameter int CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    invalidate_i,
  input  logic [31:0]             pc_i,
  output logic [31:0]             instr_o,
  output logic                    stall_o,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [32*LINE_WORDS-1:0] mem_data_i,
  output logic [CNT_W-1:0]        miss_cnt_o
);

  localparam int TAG_W = 32 - OFF_BITS;
  localparam int IDX_W = OFF_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_REQ   = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    line_valid_reg;
  logic                    drop_reg;
  logic [TAG_W-1:0]        tag_reg;
  logic [TAG_W-1:0]        miss_tag_reg;
  logic [32*LINE_WORDS-1:0] line_reg;
  logic                    mem_req_reg;
  logic [CNT_W-1:0]        miss_cnt_reg;

  logic [31:0]             line_word [LINE_WORDS];
  logic [TAG_W-1:0]        pc_tag;
  logic [IDX_W-1:0]        pc_idx;
  logic                    hit;
  logic                    miss_start;
  logic                    fill_fire;
  logic                    unused_pc_bits;

  // Byte offset within a word is irrelevant: fetch addresses are word aligned.
  assign unused_pc_bits = ^pc_i[1:0];

  assign pc_tag = pc_i[31:OFF_BITS];
  assign pc_idx = pc_i[OFF_BITS-1:2];
  assign hit    = line_valid_reg && (pc_tag == tag_reg);

  // Split the flat line register into addressable words (word 0 in the LSBs).
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
    assign line_word[gi] = line_reg[32*gi +: 32];
  end

  // A new fill starts only when the CPU is running; a stop in READY wins.
  assign miss_start = (state_reg == ST_READY) && start_i && !hit;
  // Acks are only meaningful while a request is outstanding.
  assign fill_fire  = (state_reg == ST_REQ) && mem_ack_i;

  assign mem_req_o  = mem_req_reg;
  assign mem_addr_o = {miss_tag_reg, {OFF_BITS{1'b0}}};
  assign miss_cnt_o = miss_cnt_reg;

  // Next-state decode plus the zero-latency instruction/stall outputs.
  always_comb begin
    state_next = state_reg;
    instr_o    = 32'h0;
    stall_o    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (hit) begin
          instr_o = line_word[pc_idx];
        end
        if (!start_i) begin
          state_next = ST_IDLE;
        end else if (!hit) begin
          stall_o    = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          state_next = start_i ? ST_READY : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and the memory request handshake (request held until ack).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= ST_IDLE;
      mem_req_reg  <= 1'b0;
      miss_tag_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (miss_start) begin
        mem_req_reg  <= 1'b1;
        miss_tag_reg <= pc_tag;
      end else if (fill_fire) begin
        mem_req_reg  <= 1'b0;
      end
    end
  end

  // Line contents and tag are captured from the fill data on ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      line_reg <= '0;
      tag_reg  <= '0;
    end else if (fill_fire) begin
      line_reg <= mem_data_i;
      tag_reg  <= miss_tag_reg;
    end
  end

  // Validity: an invalidate seen during a fill (including on the ack cycle)
  // lets the fill finish but leaves the line invalid so the fetch re-misses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      line_valid_reg <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      if (fill_fire) begin
        line_valid_reg <= !(drop_reg || invalidate_i);
        drop_reg       <= 1'b0;
      end else if (invalidate_i) begin
        if (state_reg == ST_REQ) begin
          drop_reg <= 1'b1;
        end else begin
          line_valid_reg <= 1'b0;
        end
      end
    end
  end

  // Count completed line fills, sticking at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      miss_cnt_reg <= '0;
    end else if (fill_fire && (miss_cnt_reg != {CNT_W{1'b1}})) begin
      miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed bench for ifetch_line_buffer with an expected-instruction queue.
module tb_ifetch_line_buffer;

  localparam int LINE_WORDS = 8;
  localparam int OFF_BITS   = 5;
  localparam int CNT_W      = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     start_i;
  logic                     invalidate_i;
  logic [31:0]              pc_i;
  logic [31:0]              instr_o;
  logic                     stall_o;
  logic                     mem_req_o;
  logic [31:0]              mem_addr_o;
  logic                     mem_ack_i;
  logic [32*LINE_WORDS-1:0] mem_data_i;
  logic [CNT_W-1:0]         miss_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  ifetch_line_buffer #(
    .LINE_WORDS(LINE_WORDS),
    .OFF_BITS  (OFF_BITS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .invalidate_i(invalidate_i),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .miss_cnt_o  (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory image: word at byte address a holds 0x1000 + a/4.
  function automatic logic [31:0] model_word(input logic [31:0] addr);
    return 32'h1000 + (addr >> 2);
  endfunction

  function automatic logic [32*LINE_WORDS-1:0] line_data(input logic [31:0] la);
    logic [32*LINE_WORDS-1:0] d;
    d = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      d[32*i +: 32] = model_word(la + 32'(4*i));
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One fetch transaction: drive pc, serve any line requests acking in the
  // ack_n-th request cycle, then compare the delivered instruction.
  task automatic fetch(input logic [31:0] pc, input int ack_n, input int exp_fills,
                       input bit drop_first);
    logic [31:0] la;
    logic [31:0] exp_instr;
    int stall_cnt;
    int req;
    int guard;
    la = {pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
    pc_i = pc;
    exp_q.push_back(model_word(pc));
    #1;
    stall_cnt = 0;
    req = 0;
    guard = 0;
    while (stall_o === 1'b1 && guard < 200) begin
      guard++;
      stall_cnt++;
      if (mem_req_o === 1'b1) begin
        req++;
        if (req == ack_n) begin
          check("mem_addr", mem_addr_o, la);
          mem_data_i = line_data(la);
          mem_ack_i = 1'b1;
          if (drop_first) invalidate_i = 1'b1;
        end
      end
      tick();
      if (mem_ack_i) begin
        req = 0;
        drop_first = 1'b0;
      end
      mem_ack_i = 1'b0;
      invalidate_i = 1'b0;
      #1;
    end
    check("stall_released", {31'b0, stall_o}, 32'h0);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_fills * (ack_n + 1)));
    exp_instr = exp_q.pop_front();
    check("instr", instr_o, exp_instr);
    $display("fetch pc=%08h instr=%08h stall_cycles=%0d miss_cnt=%0d",
             pc, instr_o, stall_cnt, miss_cnt_o);
    tick();
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    invalidate_i = 1'b0;
    pc_i = 32'h0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    tick();
    tick();
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_req", {31'b0, mem_req_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_cnt", 32'(miss_cnt_o), 32'h0);
    rst_i = 1'b1;
    tick();
    #1;
    check("idle_stall", {31'b0, stall_o}, 32'h0);
    check("idle_req", {31'b0, mem_req_o}, 32'h0);

    // T1: cold miss, ack in 3rd request cycle
    start_i = 1'b1;
    tick();
    fetch(32'h00, 3, 1, 1'b0);
    check("t1_cnt", 32'(miss_cnt_o), 32'd1);

    // T2: remaining words of the line hit with no stall
    for (int i = 1; i < LINE_WORDS; i++) begin
      fetch(32'(4*i), 1, 0, 1'b0);
    end

    // T3: new line then back to the evicted one
    fetch(32'h20, 2, 1, 1'b0);
    fetch(32'h00, 1, 1, 1'b0);
    check("t3_cnt", 32'(miss_cnt_o), 32'd3);

    // T4: invalidate coincident with ack -> line dropped, immediate re-miss
    fetch(32'h24, 2, 2, 1'b1);
    check("t4_cnt", 32'(miss_cnt_o), 32'd5);

    // T5: asynchronous reset while a request is outstanding
    pc_i = 32'h40;
    #1;
    check("t5_miss_stall", {31'b0, stall_o}, 32'h1);
    tick();
    check("t5_req_up", {31'b0, mem_req_o}, 32'h1);
    rst_i = 1'b0;
    #1;
    check("t5_req_drop", {31'b0, mem_req_o}, 32'h0);
    check("t5_stall_drop", {31'b0, stall_o}, 32'h0);
    check("t5_cnt_clear", 32'(miss_cnt_o), 32'h0);
    check("t5_addr_clear", mem_addr_o, 32'h0);
    start_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    check("t5_idle_req", {31'b0, mem_req_o}, 32'h0);
    check("t5_idle_instr", instr_o, 32'h0);
    start_i = 1'b1;
    tick();
    fetch(32'h40, 2, 1, 1'b0);
    check("t5_cnt", 32'(miss_cnt_o), 32'd1);

    // T6: start drops during the request; fill still completes, then IDLE
    pc_i = 32'h60;
    #1;
    check("t6_miss_stall", {31'b0, stall_o}, 32'h1);
    tick();
    check("t6_req_up", {31'b0, mem_req_o}, 32'h1);
    start_i = 1'b0;
    tick();
    check("t6_req_held", {31'b0, mem_req_o}, 32'h1);
    mem_data_i = line_data(32'h60);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    check("t6_req_done", {31'b0, mem_req_o}, 32'h0);
    check("t6_stall", {31'b0, stall_o}, 32'h0);
    check("t6_instr_nop", instr_o, 32'h0);
    check("t6_cnt", 32'(miss_cnt_o), 32'd2);
    // Stray ack while idle must not disturb the buffered line
    mem_data_i = {LINE_WORDS{32'hDEAD_BEEF}};
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    start_i = 1'b1;
    tick();
    fetch(32'h64, 1, 0, 1'b0);
    check("t6_cnt_final", 32'(miss_cnt_o), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
